// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifetch_pkg;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } ifetch_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } fetch_entry_t;

  // Word-align an address; the low two bits never take part in matching.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-memory read port.
// Handshake: the master raises req with a word-aligned addr and keeps both
// stable until the slave returns a one-cycle ack; rdata is valid only in
// the ack cycle. At most one request is ever outstanding.
interface inst_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/inst_fetch_fifo.sv
// Prefetch buffer holding {addr,data} entries in FIFO order; flush wins
// over push and pop.
module fetch_fifo
  import ifetch_pkg::fetch_entry_t;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  fetch_entry_t               push_entry,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output fetch_entry_t               head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state of storage, pointers and occupancy.
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    do_push = push && (count_q != CW'(DEPTH));
    do_pop  = pop && (count_q != '0);
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = push_entry;
        wr_d        = ptr_inc(wr_q);
      end
      if (do_pop) begin
        rd_d = ptr_inc(rd_q);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  // Status and head view.
  always_comb begin
    full  = (count_q == CW'(DEPTH));
    empty = (count_q == '0);
    count = count_q;
    head  = mem_q[rd_q];
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: prefetches sequential words into a small FIFO and
// presents the head word to the cpu when its address matches pc.
module inst_fetch
  import ifetch_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        pc,
  input  logic               hold,
  output logic [31:0]        inst,
  output logic               inst_valid,
  inst_fetch_if.master       imem,
  output ifetch_state_e      dbg_state,
  output logic [CNT_W-1:0]   dbg_count
);

  ifetch_state_e    state_q, state_d;
  logic [31:0]      exp_pc_q, exp_pc_d;
  logic [31:0]      fetch_addr_q, fetch_addr_d;
  logic [31:0]      req_addr_q, req_addr_d;

  logic             fifo_push, fifo_pop, fifo_flush;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     fifo_head, push_entry;

  logic             redirect, head_match, issue;
  logic [31:0]      redirect_addr, fetch_base;
  logic [CNT_W-1:0] occupancy;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (reset),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .flush      (fifo_flush),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .head       (fifo_head)
  );

  // Redirect detection, head matching and the issue condition. A redirect
  // flushes the FIFO this cycle, so the issue check sees it as empty.
  always_comb begin
    redirect      = !hold && (pc[31:2] != exp_pc_q[31:2]);
    redirect_addr = word_align(pc);
    head_match    = !fifo_empty && (fifo_head.addr[31:2] == pc[31:2]);
    fetch_base    = redirect ? redirect_addr : fetch_addr_q;
    occupancy     = redirect ? '0 : fifo_count;
    issue         = (state_q == IDLE) && (occupancy < CNT_W'(DEPTH));
  end

  // Next-state logic. Any ack seen in IDLE (e.g. right after reset) is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue) state_d = REQ;
      REQ:     if (imem.ack) state_d = IDLE;
               else if (redirect) state_d = DRAIN;
      DRAIN:   if (imem.ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address bookkeeping and FIFO control.
  always_comb begin
    exp_pc_d     = exp_pc_q;
    fetch_addr_d = fetch_base;
    req_addr_d   = req_addr_q;
    fifo_flush   = redirect;
    fifo_pop     = head_match && !hold && !redirect;
    fifo_push    = (state_q == REQ) && imem.ack && !redirect;
    push_entry   = '{addr: req_addr_q, data: imem.rdata};
    if (redirect) begin
      exp_pc_d = redirect_addr;
    end else if (fifo_pop) begin
      exp_pc_d = exp_pc_q + 32'd4;
    end
    if (issue) begin
      req_addr_d   = fetch_base;
      fetch_addr_d = fetch_base + 32'd4;
    end
  end

  // State and address registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      exp_pc_q     <= '0;
      fetch_addr_q <= '0;
      req_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      exp_pc_q     <= exp_pc_d;
      fetch_addr_q <= fetch_addr_d;
      req_addr_q   <= req_addr_d;
    end
  end

  // Outputs: request port, cpu-facing instruction and debug view.
  always_comb begin
    imem.req   = (state_q == REQ);
    imem.addr  = req_addr_q;
    inst_valid = head_match;
    inst       = head_match ? fifo_head.data : NOP_INST;
    dbg_state  = state_q;
    dbg_count  = fifo_count;
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: memory model with configurable latency, request
// address scoreboard and one task per scenario.
module tb_inst_fetch;
  import ifetch_pkg::*;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [31:0]      pc = '0;
  logic             hold = 1'b0;
  logic [31:0]      inst;
  logic             inst_valid;
  ifetch_state_e    dbg_state;
  logic [CNT_W-1:0] dbg_count;

  inst_fetch_if imem ();

  inst_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .hold       (hold),
    .inst       (inst),
    .inst_valid (inst_valid),
    .imem       (imem),
    .dbg_state  (dbg_state),
    .dbg_count  (dbg_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] exp_q[$];

  int          mem_lat = 0;
  bit          junk_ack = 1'b0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  bit          busy = 1'b0;
  int          lat_cnt = 0;
  logic [31:0] lat_addr = '0;
  int          req_cnt = 0;

  assign imem.ack   = mem_ack;
  assign imem.rdata = mem_rdata;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hC0DE_0F0F;
  endfunction

  // Memory model: captures each request once, acks after mem_lat extra
  // cycles even if req was dropped, and scores the request address.
  always @(negedge clk) begin
    logic [31:0] e;
    if (reset) begin
      mem_ack   = junk_ack;
      mem_rdata = 32'hDEAD_BEEF;
      busy      = 1'b0;
      req_cnt   = 0;
    end else if (junk_ack) begin
      mem_ack   = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
    end else begin
      mem_ack = 1'b0;
      if (busy) begin
        if (lat_cnt == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = word_of(lat_addr);
          busy      = 1'b0;
        end else begin
          lat_cnt--;
        end
      end else if (imem.req) begin
        req_cnt++;
        lat_addr = imem.addr;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_checks++;
          if (imem.addr !== e)
            $display("FAIL req_addr: got %h expected %h", imem.addr, e);
          else
            n_pass++;
        end
        if (mem_lat == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = word_of(imem.addr);
        end else begin
          busy    = 1'b1;
          lat_cnt = mem_lat - 1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut(input int lat);
    reset   = 1'b1;
    mem_lat = lat;
    exp_q.delete();
    repeat (3) step();
    reset = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int c;
    c = 0;
    while (!inst_valid && c < budget) begin
      step();
      c++;
    end
  endtask

  task automatic consume(input logic [31:0] a, input int budget);
    pc   = a;
    hold = 1'b0;
    wait_valid(budget);
    n_checks++;
    if (inst_valid !== 1'b1 || inst !== word_of(a))
      $display("FAIL consume_%h: valid=%b inst=%h expected valid=1 inst=%h", a, inst_valid, inst, word_of(a));
    else
      n_pass++;
    step();
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL %s_drained: %0d expected requests never seen, required 0", name, exp_q.size());
    else
      n_pass++;
  endtask

  // scenarios
  task automatic test_reset();
    pc = '0; hold = 1'b0; mem_lat = 0; junk_ack = 1'b1; reset = 1'b1;
    exp_q.delete();
    repeat (3) step();
    n_checks++; if (imem.req !== 1'b0) $display("FAIL rst_req: got %b expected 0", imem.req); else n_pass++;
    n_checks++; if (imem.addr !== 32'h0) $display("FAIL rst_addr: got %h expected 0", imem.addr); else n_pass++;
    n_checks++; if (inst_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", inst_valid); else n_pass++;
    n_checks++; if (inst !== 32'h0) $display("FAIL rst_inst: got %h expected 0", inst); else n_pass++;
    n_checks++; if (dbg_state !== IDLE) $display("FAIL rst_state: got %0d expected IDLE", dbg_state); else n_pass++;
    n_checks++; if (dbg_count !== '0) $display("FAIL rst_count: got %0d expected 0", dbg_count); else n_pass++;
    // release with a junk ack still present on the first edge
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    reset = 1'b0;
    step();
    junk_ack = 1'b0;
    n_checks++;
    if (dbg_state !== REQ || imem.addr !== 32'h0 || dbg_count !== '0)
      $display("FAIL first_req: state=%0d addr=%h count=%0d expected REQ/0/0", dbg_state, imem.addr, dbg_count);
    else n_pass++;
    step();
    n_checks++;
    if (inst_valid !== 1'b1 || inst !== word_of(32'h0))
      $display("FAIL first_word: valid=%b inst=%h expected 1/%h", inst_valid, inst, word_of(32'h0));
    else n_pass++;
    // pop word 0, issue request for 4 with a slow memory, then reset mid-flight
    mem_lat = 3;
    step();
    pc = 32'h4;
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (imem.req !== 1'b0 || dbg_state !== IDLE || dbg_count !== '0)
      $display("FAIL async_rst: req=%b state=%0d count=%0d expected 0/IDLE/0", imem.req, dbg_state, dbg_count);
    else n_pass++;
    repeat (2) step();
    pc = '0;
    exp_q.push_back(32'h0);
    reset = 1'b0;
    step();
    n_checks++;
    if (dbg_state !== REQ || imem.addr !== 32'h0)
      $display("FAIL no_drain_after_rst: state=%0d addr=%h expected REQ/0", dbg_state, imem.addr);
    else n_pass++;
    repeat (2) step();
    check_drained("reset");
  endtask

  task automatic test_sequential();
    pc = '0; hold = 1'b0;
    reset_dut(1);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    for (int i = 0; i < 8; i++) consume(32'(i * 4), 40);
    check_drained("seq");
  endtask

  task automatic test_full();
    pc = '0; hold = 1'b1;
    reset_dut(0);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
    repeat (30) step();
    n_checks++; if (req_cnt != 4) $display("FAIL full_req_cnt: got %0d expected 4", req_cnt); else n_pass++;
    n_checks++; if (imem.req !== 1'b0) $display("FAIL full_req_low: got %b expected 0", imem.req); else n_pass++;
    n_checks++; if (dbg_count !== 3'd4) $display("FAIL full_count: got %0d expected 4", dbg_count); else n_pass++;
    n_checks++;
    if (inst_valid !== 1'b1 || inst !== word_of(32'h0))
      $display("FAIL full_head: valid=%b inst=%h expected 1/%h", inst_valid, inst, word_of(32'h0));
    else n_pass++;
    check_drained("full");
  endtask

  task automatic test_hold();
    logic [CNT_W-1:0] prev;
    pc = '0; hold = 1'b0;
    reset_dut(0);
    consume(32'h0, 40);
    consume(32'h4, 40);
    pc = 32'h8;
    wait_valid(40);
    hold = 1'b1;
    prev = dbg_count;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (inst_valid !== 1'b1 || inst !== word_of(32'h8) || dbg_count < prev || dbg_state == DRAIN)
        $display("FAIL hold_cycle%0d: valid=%b inst=%h count=%0d prev=%0d state=%0d expected 1/%h/>=prev/not DRAIN",
                 i, inst_valid, inst, dbg_count, prev, dbg_state, word_of(32'h8));
      else n_pass++;
      prev = dbg_count;
    end
    consume(32'h8, 10);
    consume(32'hC, 40);
  endtask

  task automatic test_redirect();
    int c;
    pc = '0; hold = 1'b0;
    reset_dut(3);
    exp_q.push_back(32'h0);  exp_q.push_back(32'h4);  exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);  exp_q.push_back(32'h10); exp_q.push_back(32'h40);
    consume(32'h0, 60);
    pc = 32'h4; hold = 1'b1;
    c = 0;
    while (!(imem.req && imem.addr == 32'h10) && c < 100) begin
      step();
      c++;
    end
    n_checks++;
    if (!(imem.req === 1'b1 && imem.addr === 32'h10))
      $display("FAIL redir_pending: req=%b addr=%h expected 1/00000010", imem.req, imem.addr);
    else n_pass++;
    pc = 32'h40; hold = 1'b0;
    step();
    n_checks++;
    if (dbg_state !== DRAIN || imem.req !== 1'b0)
      $display("FAIL redir_drain: state=%0d req=%b expected DRAIN/0", dbg_state, imem.req);
    else n_pass++;
    c = 0;
    while (dbg_state == DRAIN && c < 20) begin
      n_checks++;
      if (inst_valid !== 1'b0 || imem.req !== 1'b0)
        $display("FAIL drain_quiet: valid=%b req=%b expected 0/0", inst_valid, imem.req);
      else n_pass++;
      step();
      c++;
    end
    n_checks++;
    if (dbg_state !== IDLE || dbg_count !== '0 || inst_valid !== 1'b0)
      $display("FAIL stale_dropped: state=%0d count=%0d valid=%b expected IDLE/0/0", dbg_state, dbg_count, inst_valid);
    else n_pass++;
    step();
    n_checks++;
    if (imem.req !== 1'b1 || imem.addr !== 32'h40)
      $display("FAIL redir_req: req=%b addr=%h expected 1/00000040", imem.req, imem.addr);
    else n_pass++;
    wait_valid(40);
    hold = 1'b1;
    pc = 32'h10;
    #1;
    n_checks++; if (inst_valid !== 1'b0) $display("FAIL stale_pc10: valid=%b expected 0", inst_valid); else n_pass++;
    pc = 32'h40;
    #1;
    n_checks++;
    if (inst_valid !== 1'b1 || inst !== word_of(32'h40))
      $display("FAIL redir_word: valid=%b inst=%h expected 1/%h", inst_valid, inst, word_of(32'h40));
    else n_pass++;
    check_drained("redirect");
  endtask

  task automatic test_redirect_ack();
    pc = '0; hold = 1'b0;
    reset_dut(0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h80);
    step();
    n_checks++;
    if (imem.req !== 1'b1 || imem.addr !== 32'h0)
      $display("FAIL rack_first: req=%b addr=%h expected 1/0", imem.req, imem.addr);
    else n_pass++;
    pc = 32'h80;
    step();
    n_checks++;
    if (dbg_state !== IDLE || dbg_count !== '0 || inst_valid !== 1'b0)
      $display("FAIL rack_nodrain: state=%0d count=%0d valid=%b expected IDLE/0/0", dbg_state, dbg_count, inst_valid);
    else n_pass++;
    step();
    n_checks++;
    if (imem.req !== 1'b1 || imem.addr !== 32'h80)
      $display("FAIL rack_newreq: req=%b addr=%h expected 1/00000080", imem.req, imem.addr);
    else n_pass++;
    consume(32'h80, 20);
    check_drained("redir_ack");
  endtask

  task automatic test_wrap();
    pc = 32'hFFFF_FFF8; hold = 1'b0;
    reset_dut(0);
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    step();
    n_checks++;
    if (imem.req !== 1'b1 || imem.addr !== 32'hFFFF_FFF8)
      $display("FAIL wrap_latency_req: req=%b addr=%h expected 1/fffffff8", imem.req, imem.addr);
    else n_pass++;
    step();
    n_checks++;
    if (inst_valid !== 1'b1)
      $display("FAIL wrap_latency_valid: valid=%b expected 1", inst_valid);
    else n_pass++;
    consume(32'hFFFF_FFF8, 20);
    consume(32'hFFFF_FFFC, 20);
    consume(32'h0000_0000, 20);
    check_drained("wrap");
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_full();
    test_hold();
    test_redirect();
    test_redirect_ack();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Port: clk  in  1  rising-edge clock shared with cpu.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: pc  in  32  fetch address driven by cpu.
REQ-005 Port: hold  in  1  cpu fetch stall; the current instruction stays presented and is not consumed.
REQ-006 Port: inst  out  32  instruction for pc; 32'h0000_0000 (NOP) when inst_valid=0.
REQ-007 Port: inst_valid  out  1  inst is the memory word at pc.
REQ-008 Port: imem_req  out  1  read request to instruction memory; held high until imem_ack.
REQ-009 Port: imem_addr  out  32  word address of the request, bits[1:0]=0; stable while imem_req=1.
REQ-010 Port: imem_ack  in  1  one-cycle completion strobe; imem_rdata is valid in the same cycle.
REQ-011 Port: imem_rdata  in  32  returned instruction word.

Function
REQ-012 The block SHALL buffer up to DEPTH=4 prefetched {addr,data} entries in FIFO order.
REQ-013 At most one imem request SHALL be outstanding.
REQ-014 A request SHALL issue only when count+outstanding<DEPTH, so every accepted ack always fits.
REQ-015 fetch_addr SHALL increment by 4 per issued request and wrap 32'hFFFF_FFFC -> 32'h0.
REQ-016 inst and inst_valid SHALL be combinational: valid=1 when count>0 and head.addr==pc, else inst=NOP and valid=0.
REQ-017 Pop SHALL occur at a clock edge when inst_valid=1 and hold=0; exp_pc then becomes pc+4.
REQ-018 A redirect SHALL be detected when pc[31:2]!=exp_pc[31:2] and hold=0.
REQ-019 On redirect, the FIFO SHALL be emptied and exp_pc and fetch_addr set to {pc[31:2],2'b00}.
REQ-020 pc[1:0] SHALL be ignored in all comparisons.
REQ-021 FSM states SHALL be IDLE (no request), REQ (imem_req=1, awaiting ack) and DRAIN (imem_req=0, discarding one stale ack).
REQ-022 Transitions:
- IDLE->REQ when the issue condition of REQ-014 holds.
- REQ->IDLE on ack without redirect; push the entry.
- REQ->DRAIN on redirect without ack.
- REQ->IDLE on redirect with ack in the same cycle; discard the data.
- DRAIN->IDLE on ack; discard the data.
REQ-023 In DRAIN, imem_req SHALL be 0 and no new request SHALL issue until the stale ack arrives.
REQ-024 If push and pop occur in the same cycle, count SHALL stay unchanged and both operations SHALL complete.
REQ-025 hold=1 SHALL suppress both pop and redirect detection; prefetch SHALL continue while space remains.
REQ-026 Best-case latency: on a redirect to A with zero-wait memory, imem_req=1 with addr A on the next cycle, and inst_valid=1 the cycle after ack.

Reset
REQ-027 On reset assertion, the block SHALL empty the FIFO and force the FSM to IDLE.
REQ-028 On reset assertion, exp_pc and fetch_addr SHALL be 0.
REQ-029 On reset assertion, the outputs SHALL be imem_req=0, imem_addr=0, inst_valid=0 and inst=NOP.
REQ-030 An imem_ack arriving while reset is asserted, or on the first cycle after release, SHALL be ignored.
REQ-031 Reset asserted with a request in flight SHALL drop the request with no drain.
REQ-032 The memory side SHALL be reset together with the block.

Structure
REQ-033 Package ifetch_pkg SHALL hold DEPTH=4, NOP_INST=32'h0 and the FSM enum {IDLE,REQ,DRAIN}.
REQ-034 Storage SHALL be a sub-module fetch_fifo with push, pop, flush, full, empty, count and head outputs, parameterised on DEPTH.
REQ-035 The FSM, redirect detection and address logic SHALL reside in inst_fetch.

Verification
REQ-036 Scenario: reset release, pc steps 0,4,8,... with 1-cycle ack memory -> first request to addr 0; words returned in order; inst_valid=1 for each pc once its word has arrived.
REQ-037 Scenario: pc stays 0 with no pops until full -> exactly 4 requests (0x0,0x4,0x8,0xC); then imem_req=0.
REQ-038 Scenario: redirect pc=0x40 while the request for 0x10 is pending, ack 3 cycles later -> state DRAIN; stale data not visible; next imem_addr=0x40; inst_valid=1 only for pc=0x40.
REQ-039 Scenario: redirect in the same cycle as ack -> no DRAIN; next request at the new pc.
REQ-040 Scenario: hold=1 for 3 cycles at pc=0x8 -> same inst presented each cycle; count unchanged or rising; no redirect.
REQ-041 Scenario: redirect to pc=0xFFFF_FFF8 -> requests to 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0 (wrap).
